// File: rtl/shift_unit.sv
// Two-stage valid/ready ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX, 8-bit immediate rotate).
// Define SHIFT_UNIT_CARRY_EN to build the carry-in/carry-out path; otherwise cout is tied to 0.
module shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             cout
);
    localparam int unsigned LW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_LSL = 3'b000,
        OP_LSR = 3'b001,
        OP_ASR = 3'b010,
        OP_ROR = 3'b011,
        OP_RRX = 3'b100,
        OP_IMM = 3'b101,
        OP_PS0 = 3'b110,
        OP_PS1 = 3'b111
    } op_e;

    logic v1, v2, adv2;
    logic s1_cin;
    logic carry;

    assign adv2      = !v2 || out_ready;
    assign in_ready  = !v1 || adv2;
    assign out_valid = v2;

    // Amount decode: flags are taken on the full-width amt so large amounts never alias.
    op_e           dec_op;
    logic          dec_zero, dec_lt, dec_eq;
    logic [LW-1:0] dec_sh;

    always_comb begin
        dec_op   = op_e'(op);
        dec_lt   = 32'(amt) < 32'(WIDTH);
        dec_eq   = 32'(amt) == 32'(WIDTH);
        dec_zero = (amt == '0);
        dec_sh   = LW'(amt);
        if (dec_op == OP_IMM) begin
            dec_zero = (data_in[11:8] == 4'd0);
            dec_sh   = LW'({data_in[11:8], 1'b0});
        end
    end

    op_e            s1_op;
    logic [WIDTH-1:0] s1_data;
    logic [LW-1:0]  s1_sh;
    logic           s1_zero, s1_lt, s1_eq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_op   <= OP_LSL;
            s1_data <= '0;
            s1_sh   <= '0;
            s1_zero <= 1'b0;
            s1_lt   <= 1'b0;
            s1_eq   <= 1'b0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_op   <= dec_op;
                s1_data <= data_in;
                s1_sh   <= dec_sh;
                s1_zero <= dec_zero;
                s1_lt   <= dec_lt;
                s1_eq   <= dec_eq;
            end
        end
    end

    // Shifts carry an extra bit so the last bit shifted out lands in a fixed position.
    logic [WIDTH:0]   ext_l, ext_r, ext_a;
    logic [WIDTH-1:0] rot_in, rot_res, res;
    logic [LW-1:0]    neg_sh;
    logic             sign;

    always_comb begin
        ext_l   = {1'b0, s1_data} << s1_sh;
        ext_r   = {s1_data, 1'b0} >> s1_sh;
        ext_a   = $signed({s1_data, 1'b0}) >>> s1_sh;
        sign    = s1_data[WIDTH-1];
        rot_in  = (s1_op == OP_IMM) ? {{(WIDTH-8){1'b0}}, s1_data[7:0]} : s1_data;
        neg_sh  = '0 - s1_sh;
        rot_res = (rot_in >> s1_sh) | (rot_in << neg_sh);
        res     = s1_data;
        carry   = s1_cin;
        case (s1_op)
            OP_LSL: if (!s1_zero) begin
                if (s1_lt) begin
                    res   = ext_l[WIDTH-1:0];
                    carry = ext_l[WIDTH];
                end else begin
                    res   = '0;
                    carry = s1_eq ? s1_data[0] : 1'b0;
                end
            end
            OP_LSR: if (!s1_zero) begin
                if (s1_lt) begin
                    res   = ext_r[WIDTH:1];
                    carry = ext_r[0];
                end else begin
                    res   = '0;
                    carry = s1_eq ? s1_data[WIDTH-1] : 1'b0;
                end
            end
            OP_ASR: if (!s1_zero) begin
                if (s1_lt) begin
                    res   = ext_a[WIDTH:1];
                    carry = ext_a[0];
                end else begin
                    res   = {WIDTH{sign}};
                    carry = sign;
                end
            end
            OP_ROR: if (!s1_zero) begin
                res   = rot_res;
                carry = rot_res[WIDTH-1];
            end
            OP_RRX: begin
                res   = {s1_cin, s1_data[WIDTH-1:1]};
                carry = s1_data[0];
            end
            OP_IMM: begin
                res   = rot_res;
                carry = s1_zero ? s1_cin : rot_res[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2       <= 1'b0;
            data_out <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) data_out <= res;
        end
    end

`ifdef SHIFT_UNIT_CARRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       s1_cin <= 1'b0;
        else if (in_ready && in_valid) s1_cin <= cin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cout <= 1'b0;
        else if (adv2 && v1)  cout <= carry;
    end
`else
    logic unused_carry;
    assign s1_cin       = 1'b0;
    assign cout         = 1'b0;
    assign unused_carry = ^{cin, carry};
`endif

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed vector table, pipeline sequences and
// randomized traffic checked against an arithmetic reference model.
module tb_shift_unit;
    localparam int W = 32;
`ifdef SHIFT_UNIT_CARRY_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic        clk, rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [2:0]  op;
    logic [31:0] data_in, data_out;
    logic [7:0]  amt;

    shift_unit #(.WIDTH(W), .AMT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .data_in(data_in), .amt(amt), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .cout(cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { string name; logic [31:0] d; logic c; int acc; } exp_t;
    typedef struct { logic [2:0] op; logic [31:0] d; logic [7:0] amt; logic cin;
                     logic [31:0] ed; logic ec; string name; } vec_t;

    exp_t        q[$];
    vec_t        tbl[16];
    int          n_chk, n_fail, cyc, n_out, n_acc;
    bit          lat_chk;
    logic [31:0] nx_d;
    logic        nx_c;
    string       nx_name;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] v, input int unsigned k);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[(i + k) % 32];
        return r;
    endfunction

    function automatic logic [32:0] model(input logic [2:0] mop, input logic [31:0] d,
                                          input logic [7:0] a, input logic ci_in);
        int unsigned n, k;
        logic [31:0] r;
        logic c, ci;
        n  = a;
        ci = CE ? ci_in : 1'b0;
        r  = d;
        c  = ci;
        case (mop)
            3'd0: if (n != 0) begin
                if (n < 32) begin r = d << n; c = d[32-n]; end
                else begin r = '0; c = (n == 32) ? d[0] : 1'b0; end
            end
            3'd1: if (n != 0) begin
                if (n < 32) begin r = d >> n; c = d[n-1]; end
                else begin r = '0; c = (n == 32) ? d[31] : 1'b0; end
            end
            3'd2: if (n != 0) begin
                if (n < 32) begin r = 32'($signed(d) >>> n); c = d[n-1]; end
                else begin r = {32{d[31]}}; c = d[31]; end
            end
            3'd3: if (n != 0) begin
                k = n % 32;
                r = rotr(d, k);
                c = (k == 0) ? d[31] : r[31];
            end
            3'd4: begin r = {ci, d[31:1]}; c = d[0]; end
            3'd5: begin
                k = (2 * int'(d[11:8])) % 32;
                r = rotr({24'd0, d[7:0]}, k);
                c = (d[11:8] == 4'd0) ? ci : r[31];
            end
            default: ;
        endcase
        return {c & CE, r};
    endfunction

    // One clock: score the output transfer, record the input transfer, then advance.
    task automatic cycle();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got data %h with no pending operation", data_out);
            end else begin
                e = q.pop_front();
                chk({e.name, "_data"}, data_out, e.d);
                chk({e.name, "_cout"}, {31'd0, cout}, {31'd0, e.c});
                if (lat_chk) chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'd2);
            end
        end
        if (in_valid && in_ready) begin
            e.name = nx_name; e.d = nx_d; e.c = nx_c; e.acc = cyc;
            q.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_rand(input string name);
        logic [32:0] m;
        op      = 3'($urandom_range(0, 7));
        data_in = $urandom;
        cin     = 1'($urandom);
        case ($urandom_range(0, 7))
            0: amt = 8'd0;
            1: amt = 8'd1;
            2: amt = 8'd31;
            3: amt = 8'd32;
            4: amt = 8'd33;
            5: amt = 8'd64;
            default: amt = 8'($urandom);
        endcase
        m       = model(op, data_in, amt, cin);
        nx_d    = m[31:0];
        nx_c    = m[32];
        nx_name = name;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        int acc0, out0;
        logic [31:0] held_d;
        logic        held_c, have_hold;

        tbl[0]  = '{3'd5, 32'h0000_04FF, 8'd0,   1'b0, 32'hFF00_0000, 1'b1, "imm_rot8"};
        tbl[1]  = '{3'd5, 32'h0000_00AB, 8'd0,   1'b1, 32'h0000_00AB, 1'b1, "imm_norot_c1"};
        tbl[2]  = '{3'd5, 32'h0000_00AB, 8'd0,   1'b0, 32'h0000_00AB, 1'b0, "imm_norot_c0"};
        tbl[3]  = '{3'd0, 32'h8000_0001, 8'd1,   1'b0, 32'h0000_0002, 1'b1, "lsl_1"};
        tbl[4]  = '{3'd1, 32'h8000_0000, 8'd32,  1'b0, 32'h0000_0000, 1'b1, "lsr_32"};
        tbl[5]  = '{3'd1, 32'h8000_0000, 8'd33,  1'b0, 32'h0000_0000, 1'b0, "lsr_33"};
        tbl[6]  = '{3'd2, 32'h8000_0000, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1, "asr_40"};
        tbl[7]  = '{3'd3, 32'h0000_0001, 8'd33,  1'b0, 32'h8000_0000, 1'b1, "ror_33"};
        tbl[8]  = '{3'd3, 32'h8000_0000, 8'd64,  1'b0, 32'h8000_0000, 1'b1, "ror_64"};
        tbl[9]  = '{3'd4, 32'h0000_0003, 8'd0,   1'b1, CE ? 32'h8000_0001 : 32'h0000_0001, 1'b1, "rrx_c1"};
        tbl[10] = '{3'd0, 32'h1234_5678, 8'd0,   1'b1, 32'h1234_5678, 1'b1, "lsl_0_c1"};
        tbl[11] = '{3'd0, 32'h0000_0001, 8'd32,  1'b0, 32'h0000_0000, 1'b1, "lsl_32"};
        tbl[12] = '{3'd2, 32'h4000_0000, 8'd255, 1'b0, 32'h0000_0000, 1'b0, "asr_255"};
        tbl[13] = '{3'd7, 32'hDEAD_BEEF, 8'd9,   1'b1, 32'hDEAD_BEEF, 1'b1, "pass_c1"};
        tbl[14] = '{3'd3, 32'h1234_5678, 8'd4,   1'b0, 32'h8123_4567, 1'b1, "ror_4"};
        tbl[15] = '{3'd5, 32'hABCD_EF3C, 8'd0,   1'b0, 32'h0000_00F0, 1'b0, "imm_rot30"};

        n_chk = 0; n_fail = 0; cyc = 0; n_out = 0; n_acc = 0; lat_chk = 1'b1;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; data_in = '0; amt = '0; cin = 1'b0;
        nx_d = '0; nx_c = 1'b0; nx_name = "none";
        #2;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data_out", data_out, 32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors, one at a time with a 2-cycle latency check.
        foreach (tbl[i]) begin
            op = tbl[i].op; data_in = tbl[i].d; amt = tbl[i].amt; cin = tbl[i].cin;
            nx_d = tbl[i].ed; nx_c = tbl[i].ec & CE; nx_name = tbl[i].name;
            in_valid = 1'b1;
            cycle();
            drain();
        end

        // Back-to-back: 8 ops, one per cycle, results consecutive and in order.
        out0 = n_out;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_rand("b2b");
            cycle();
        end
        drain();
        chk("b2b_count", 32'(n_out - out0), 32'd8);
        lat_chk = 1'b0;

        // Backpressure: consumer stalled for 5 cycles while the producer keeps issuing.
        acc0 = n_acc; out0 = n_out; have_hold = 1'b0; held_d = '0; held_c = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_rand("stall");
            cycle();
            if (out_valid) begin
                if (have_hold) begin
                    chk("stall_data_hold", data_out, held_d);
                    chk("stall_cout_hold", {31'd0, cout}, {31'd0, held_c});
                end else begin
                    held_d = data_out; held_c = cout; have_hold = 1'b1;
                end
            end
        end
        chk("stall_accepts", 32'(n_acc - acc0), 32'd2);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rand("release");
            cycle();
        end
        drain();
        chk("release_no_loss", 32'(n_out - out0), 32'(n_acc - acc0));

        // Reset with two operations in flight: nothing from them may emerge.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_rand("flushed");
            cycle();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_data_out", data_out, 32'd0);
        chk("midreset_cout", {31'd0, cout}, 32'd0);
        q.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        out0 = n_out; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("midreset_no_stale", 32'(n_out - out0), 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);

        // Randomized traffic with random valid/ready against the reference model.
        acc0 = n_acc; out0 = n_out;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            set_rand("rand");
            cycle();
        end
        drain();
        chk("rand_count", 32'(n_out - out0), 32'(n_acc - acc0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
